// File: rtl/csi2_pkg.sv
// Shared types and constants for the CSI-2 receive packet parser.
package csi2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  // Data types at or below this value are short packets.
  localparam logic [5:0]  SHORT_DT_MAX = 6'h0F;
  // CRC-16 x^16+x^12+x^5+1 in bit-reflected form.
  localparam logic [15:0] CRC_POLY     = 16'h8408;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;

endpackage

// File: rtl/csi2_crc16.sv
// One byte of the reflected CSI-2 payload CRC-16, purely combinational.
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/csi2_rx_packet_parser.sv
// CSI-2 byte-stream packet parser: header decode, payload forwarding, length/truncation errors.
// Optional payload CRC check is built when CSI2_CRC_CHECK_EN is defined.
module csi2_rx_packet_parser
  import csi2_pkg::*;
#(
  parameter int MAX_WC = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_hs_active,
  output logic        hdr_valid,
  output logic [1:0]  hdr_vc,
  output logic [5:0]  hdr_dt,
  output logic [15:0] hdr_wc,
  output logic [7:0]  hdr_ecc,
  output logic        hdr_short,
  output logic        pl_valid,
  output logic [7:0]  pl_data,
  output logic        pl_last,
  output logic        pkt_done,
  output logic        crc_err,
  output logic        len_err,
  output logic        trunc_err
);

  localparam logic [31:0] MAX_WC_U = 32'(MAX_WC);

  state_e      state_q, state_d;
  logic [7:0]  di_q, di_d, b1_q, b1_d, b2_q, b2_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hdr_valid_q, hdr_valid_d, hdr_short_q, hdr_short_d;
  logic [1:0]  hdr_vc_q, hdr_vc_d;
  logic [5:0]  hdr_dt_q, hdr_dt_d;
  logic [15:0] hdr_wc_q, hdr_wc_d;
  logic [7:0]  hdr_ecc_q, hdr_ecc_d;
  logic        pl_valid_q, pl_valid_d, pl_last_q, pl_last_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pkt_done_q, pkt_done_d, len_err_q, len_err_d, trunc_err_q, trunc_err_d;
  logic [15:0] wc_w;
  logic        is_short_w, bad_len_w;

`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d, crc_next;
  logic [7:0]  crc_lo_q, crc_lo_d;
  logic        crc_err_q, crc_err_d;

  csi2_crc16 u_crc16 (
    .crc_in  (crc_q),
    .data    (in_data),
    .crc_out (crc_next)
  );
`endif

  assign wc_w       = {b2_q, b1_q};
  assign is_short_w = (di_q[5:0] <= SHORT_DT_MAX);
  assign bad_len_w  = (wc_w == 16'd0) || (32'(wc_w) > MAX_WC_U);

  always_comb begin
    state_d     = state_q;
    di_d        = di_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    hcnt_d      = hcnt_q;
    cnt_d       = cnt_q;
    hdr_valid_d = 1'b0;
    hdr_short_d = hdr_short_q;
    hdr_vc_d    = hdr_vc_q;
    hdr_dt_d    = hdr_dt_q;
    hdr_wc_d    = hdr_wc_q;
    hdr_ecc_d   = hdr_ecc_q;
    pl_valid_d  = 1'b0;
    pl_last_d   = 1'b0;
    pl_data_d   = pl_data_q;
    pkt_done_d  = 1'b0;
    len_err_d   = 1'b0;
    trunc_err_d = 1'b0;
`ifdef CSI2_CRC_CHECK_EN
    crc_d       = crc_q;
    crc_lo_d    = crc_lo_q;
    crc_err_d   = 1'b0;
`endif
    // Losing HS mid-packet wins over any byte presented in the same cycle.
    if ((state_q == ST_HDR || state_q == ST_PAYLOAD || state_q == ST_CRC) && !in_hs_active) begin
      trunc_err_d = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (in_hs_active && in_valid) begin
          di_d    = in_data;
          hcnt_d  = 2'd1;
          state_d = ST_HDR;
        end
        ST_HDR: if (in_valid) begin
          if (hcnt_q == 2'd1) begin
            b1_d   = in_data;
            hcnt_d = 2'd2;
          end else if (hcnt_q == 2'd2) begin
            b2_d   = in_data;
            hcnt_d = 2'd3;
          end else begin
            hdr_valid_d = 1'b1;
            hdr_vc_d    = di_q[7:6];
            hdr_dt_d    = di_q[5:0];
            hdr_wc_d    = wc_w;
            hdr_ecc_d   = in_data;
            hdr_short_d = is_short_w;
            if (is_short_w) begin
              state_d = ST_IDLE;
            end else if (bad_len_w) begin
              len_err_d = 1'b1;
              state_d   = ST_DRAIN;
            end else begin
              cnt_d   = wc_w;
              state_d = ST_PAYLOAD;
`ifdef CSI2_CRC_CHECK_EN
              crc_d   = CRC_INIT;
`endif
            end
          end
        end
        ST_PAYLOAD: if (in_valid) begin
          pl_valid_d = 1'b1;
          pl_data_d  = in_data;
          pl_last_d  = (cnt_q == 16'd1);
          cnt_d      = cnt_q - 16'd1;
`ifdef CSI2_CRC_CHECK_EN
          crc_d      = crc_next;
`endif
          if (cnt_q == 16'd1) begin
            hcnt_d  = 2'd0;
            state_d = ST_CRC;
          end
        end
        ST_CRC: if (in_valid) begin
          if (hcnt_q == 2'd0) begin
            hcnt_d   = 2'd1;
`ifdef CSI2_CRC_CHECK_EN
            crc_lo_d = in_data;
`endif
          end else begin
            pkt_done_d = 1'b1;
            state_d    = ST_DRAIN;
`ifdef CSI2_CRC_CHECK_EN
            crc_err_d  = ({in_data, crc_lo_q} != crc_q);
`endif
          end
        end
        ST_DRAIN: if (!in_hs_active) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      di_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      hcnt_q      <= '0;
      cnt_q       <= '0;
      hdr_valid_q <= 1'b0;
      hdr_short_q <= 1'b0;
      hdr_vc_q    <= '0;
      hdr_dt_q    <= '0;
      hdr_wc_q    <= '0;
      hdr_ecc_q   <= '0;
      pl_valid_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      pl_data_q   <= '0;
      pkt_done_q  <= 1'b0;
      len_err_q   <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      di_q        <= di_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      hcnt_q      <= hcnt_d;
      cnt_q       <= cnt_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_short_q <= hdr_short_d;
      hdr_vc_q    <= hdr_vc_d;
      hdr_dt_q    <= hdr_dt_d;
      hdr_wc_q    <= hdr_wc_d;
      hdr_ecc_q   <= hdr_ecc_d;
      pl_valid_q  <= pl_valid_d;
      pl_last_q   <= pl_last_d;
      pl_data_q   <= pl_data_d;
      pkt_done_q  <= pkt_done_d;
      len_err_q   <= len_err_d;
      trunc_err_q <= trunc_err_d;
    end
  end

`ifdef CSI2_CRC_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q     <= '0;
      crc_lo_q  <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_lo_q  <= crc_lo_d;
      crc_err_q <= crc_err_d;
    end
  end
  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign hdr_valid = hdr_valid_q;
  assign hdr_vc    = hdr_vc_q;
  assign hdr_dt    = hdr_dt_q;
  assign hdr_wc    = hdr_wc_q;
  assign hdr_ecc   = hdr_ecc_q;
  assign hdr_short = hdr_short_q;
  assign pl_valid  = pl_valid_q;
  assign pl_data   = pl_data_q;
  assign pl_last   = pl_last_q;
  assign pkt_done  = pkt_done_q;
  assign len_err   = len_err_q;
  assign trunc_err = trunc_err_q;

endmodule
